// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller and its score counter.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_RESPAWN = 3'd2,
        ST_OVER    = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int          DIGITS        = 4;
    localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

endpackage

// File: rtl/game_sequencer_if.sv
// Player/world signal bundle between the sequencer (slave) and its surroundings (master).
interface game_sequencer_if;
    logic        start;
    logic        frame_tick;
    logic        key_left;
    logic        key_right;
    logic        key_fire;
    logic        key_pause;
    logic        enemy_hit;
    logic        player_hit;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        move_left;
    logic        move_right;
    logic        fire_req;
    logic        world_run;
    logic        game_over;

    modport slave (
        input  start, frame_tick, key_left, key_right, key_fire, key_pause,
               enemy_hit, player_hit,
        output state, lives, score, move_left, move_right, fire_req,
               world_run, game_over
    );

    modport master (
        output start, frame_tick, key_left, key_right, key_fire, key_pause,
               enemy_hit, player_hit,
        input  state, lives, score, move_left, move_right, fire_req,
               world_run, game_over
    );
endinterface

// File: rtl/bcd_score_counter.sv
// Four-digit ripple-carry BCD score counter with synchronous clear, saturating at 9999.
module bcd_score_counter
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] score
);

    bcd_digit_t [DIGITS-1:0] digits;
    bcd_digit_t [DIGITS-1:0] digits_next;
    logic                    carry;

    always_comb begin
        digits_next = digits;
        carry       = 1'b1;
        if (digits != SCORE_MAX_BCD) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (digits[i] == 4'd9) begin
                        digits_next[i] = 4'd0;
                    end else begin
                        digits_next[i] = digits[i] + 4'd1;
                        carry          = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            digits <= '0;
        end else if (inc) begin
            digits <= digits_next;
        end
    end

    assign score = digits;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: match phases, per-frame move/fire commands, lives and BCD score.
// Optional pause support is built when GAME_SEQUENCER_PAUSE_EN is defined.
//
// state   | meaning
// IDLE    | attract, waiting for a start press
// PLAY    | world running, keys become move/fire pulses on frame_tick
// RESPAWN | player was hit, world frozen for RESPAWN_FRAMES ticks
// OVER    | no lives left, game_over shown for OVER_FRAMES ticks
// PAUSE   | frozen until the next key_pause (optional build only)
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int FIRE_COOLDOWN  = 8,
    parameter int RESPAWN_FRAMES = 60,
    parameter int OVER_FRAMES    = 180
) (
    input  logic board_clk,
    input  logic reset,
    game_sequencer_if.slave bus
);

    logic       start_meta, start_sync, start_prev, start_edge;
    state_t     st;
    logic [2:0] lives_q;
    logic [7:0] cooldown, timer;
    logic       move_left_q, move_right_q, fire_q, world_run_q, game_over_q;
    logic       pause_req;
    logic       score_clear, score_inc;

`ifdef GAME_SEQUENCER_PAUSE_EN
    assign pause_req = bus.key_pause;
`else
    assign pause_req = 1'b0;
`endif

    always_ff @(posedge board_clk) begin
        if (reset) begin
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            start_meta <= bus.start;
            start_sync <= start_meta;
            start_prev <= start_sync;
        end
    end

    assign start_edge  = start_sync & ~start_prev;
    assign score_clear = (st == ST_IDLE) && start_edge;
    assign score_inc   = (st == ST_PLAY) && bus.enemy_hit && !pause_req;

    always_ff @(posedge board_clk) begin
        if (reset) begin
            st           <= ST_IDLE;
            lives_q      <= 3'd0;
            cooldown     <= 8'd0;
            timer        <= 8'd0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            fire_q       <= 1'b0;
            world_run_q  <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            fire_q       <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (start_edge) begin
                        st          <= ST_PLAY;
                        lives_q     <= 3'(LIVES);
                        cooldown    <= 8'd0;
                        world_run_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (pause_req) begin
                        st          <= ST_PAUSE;
                        world_run_q <= 1'b0;
                    end else begin
                        if (bus.frame_tick) begin
                            move_left_q  <= bus.key_left & ~bus.key_right;
                            move_right_q <= bus.key_right & ~bus.key_left;
                            if (bus.key_fire && cooldown == 8'd0) begin
                                fire_q   <= 1'b1;
                                cooldown <= 8'(FIRE_COOLDOWN - 1);
                            end else if (cooldown != 8'd0) begin
                                cooldown <= cooldown - 8'd1;
                            end
                        end
                        // A hit overrides any cooldown loaded by a coincident tick.
                        if (bus.player_hit) begin
                            lives_q     <= lives_q - 3'd1;
                            world_run_q <= 1'b0;
                            if (lives_q == 3'd1) begin
                                st          <= ST_OVER;
                                timer       <= 8'(OVER_FRAMES);
                                game_over_q <= 1'b1;
                            end else begin
                                st       <= ST_RESPAWN;
                                timer    <= 8'(RESPAWN_FRAMES);
                                cooldown <= 8'd0;
                            end
                        end
                    end
                end
                ST_RESPAWN: begin
                    if (bus.frame_tick) begin
                        timer <= timer - 8'd1;
                        if (timer == 8'd1) begin
                            st          <= ST_PLAY;
                            world_run_q <= 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (bus.frame_tick) begin
                        timer <= timer - 8'd1;
                        if (timer == 8'd1) begin
                            st          <= ST_IDLE;
                            game_over_q <= 1'b0;
                        end
                    end
                end
`ifdef GAME_SEQUENCER_PAUSE_EN
                ST_PAUSE: begin
                    if (pause_req) begin
                        st          <= ST_PLAY;
                        world_run_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    st          <= ST_IDLE;
                    world_run_q <= 1'b0;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    bcd_score_counter u_score (
        .clk   (board_clk),
        .reset (reset),
        .clear (score_clear),
        .inc   (score_inc),
        .score (bus.score)
    );

    assign bus.state      = st;
    assign bus.lives      = lives_q;
    assign bus.move_left  = move_left_q;
    assign bus.move_right = move_right_q;
    assign bus.fire_req   = fire_q;
    assign bus.world_run  = world_run_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with default parameters (3 lives, cooldown 8, 60/180 frames).
module tb_game_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    game_sequencer_if bus ();

    game_sequencer dut (
        .board_clk (clk),
        .reset     (reset),
        .bus       (bus)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic start_game(input int hold);
        bus.start = 1'b1;
        step();
        check("start_lat1", bus.state, 0);
        step();
        check("start_lat2", bus.state, 0);
        step();
        check("start_play", bus.state, 1);
        check("start_lives", bus.lives, 3);
        check("start_score", bus.score, 0);
        check("start_run", bus.world_run, 1);
        step(hold);
        check("start_held_once", bus.state, 1);
        bus.start = 1'b0;
        step(3);
    endtask

    task automatic player_hit_pulse();
        bus.player_hit = 1'b1;
        step();
        bus.player_hit = 1'b0;
    endtask

    task automatic respawn_wait(input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == 1) begin
                check("respawn_no_fire", bus.fire_req, 0);
                check("respawn_frozen", bus.world_run, 0);
            end
            step();
            check(i < n ? "respawn_hold" : "respawn_exit", bus.state, i < n ? 2 : 1);
        end
        check("respawn_run", bus.world_run, 1);
    endtask

    task automatic over_wait(input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            step();
            check(i < n ? "over_hold" : "over_exit", bus.state, i < n ? 3 : 0);
            check("over_flag", bus.game_over, i < n ? 1 : 0);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.frame_tick = 1'b0;
        bus.key_left   = 1'b0;
        bus.key_right  = 1'b0;
        bus.key_fire   = 1'b0;
        bus.key_pause  = 1'b0;
        bus.enemy_hit  = 1'b0;
        bus.player_hit = 1'b0;
        step(2);
        reset = 1'b0;
        step();
        check("rst_state", bus.state, 0);
        check("rst_lives", bus.lives, 0);
        check("rst_score", bus.score, 0);
        check("rst_run", bus.world_run, 0);
        check("rst_over", bus.game_over, 0);
        check("rst_fire", bus.fire_req, 0);

        // Game 1: start held 10 cycles, fire cooldown, moves, score carry/saturation.
        start_game(7);

        bus.key_fire = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("fire_tick", bus.fire_req, (i % 8) == 1);
            step();
            check("fire_width", bus.fire_req, 0);
        end
        bus.key_fire = 1'b0;

        bus.key_left = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("move_left", bus.move_left, 1);
            check("move_left_r", bus.move_right, 0);
            step();
            check("move_left_width", bus.move_left, 0);
        end
        bus.key_right = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("move_both_l", bus.move_left, 0);
            check("move_both_r", bus.move_right, 0);
            step();
        end
        bus.key_left = 1'b0;
        tick();
        check("move_right", bus.move_right, 1);
        check("move_right_l", bus.move_left, 0);
        bus.key_right = 1'b0;
        step();

`ifdef GAME_SEQUENCER_PAUSE_EN
        bus.key_fire = 1'b1;
        tick();
        check("pause_pre_fire", bus.fire_req, 1);
        step();
        bus.key_pause = 1'b1;
        step();
        bus.key_pause = 1'b0;
        check("pause_enter", bus.state, 4);
        check("pause_run", bus.world_run, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_no_fire", bus.fire_req, 0);
            step();
        end
        bus.enemy_hit = 1'b1;
        step();
        bus.enemy_hit = 1'b0;
        check("pause_hit_ignored", bus.score, 0);
        bus.key_pause = 1'b1;
        step();
        bus.key_pause = 1'b0;
        check("pause_exit", bus.state, 1);
        check("pause_exit_run", bus.world_run, 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("pause_cooldown_frozen", bus.fire_req, i == 8);
            step();
        end
        bus.key_fire = 1'b0;
`else
        bus.key_pause = 1'b1;
        step();
        bus.key_pause = 1'b0;
        step();
        check("pause_unused", bus.state, 1);
        check("pause_unused_run", bus.world_run, 1);
`endif

        bus.enemy_hit = 1'b1;
        step();
        check("score_first", bus.score, 16'h0001);
        step(98);
        bus.enemy_hit = 1'b0;
        check("score_99", bus.score, 16'h0099);
        bus.enemy_hit = 1'b1;
        step();
        bus.enemy_hit = 1'b0;
        check("score_carry", bus.score, 16'h0100);
        bus.enemy_hit = 1'b1;
        step(9899);
        bus.enemy_hit = 1'b0;
        check("score_9999", bus.score, 16'h9999);
        bus.enemy_hit = 1'b1;
        step();
        bus.enemy_hit = 1'b0;
        check("score_saturate", bus.score, 16'h9999);

        // Three player hits: two respawns then game over, score retained.
        bus.key_fire = 1'b1;
        player_hit_pulse();
        check("hit1_lives", bus.lives, 2);
        check("hit1_state", bus.state, 2);
        check("hit1_run", bus.world_run, 0);
        player_hit_pulse();
        check("respawn_hit_ignored", bus.lives, 2);
        bus.start = 1'b1;
        step(5);
        check("respawn_start_ignored", bus.state, 2);
        bus.start = 1'b0;
        step(3);
        respawn_wait(60);
        player_hit_pulse();
        check("hit2_lives", bus.lives, 1);
        check("hit2_state", bus.state, 2);
        respawn_wait(60);
        player_hit_pulse();
        check("hit3_lives", bus.lives, 0);
        check("hit3_state", bus.state, 3);
        check("hit3_over", bus.game_over, 1);
        check("hit3_run", bus.world_run, 0);
        bus.key_fire = 1'b0;
        bus.start = 1'b1;
        step(5);
        check("over_start_ignored", bus.state, 3);
        bus.start = 1'b0;
        step(3);
        over_wait(180);
        check("idle_score_kept", bus.score, 16'h9999);
        check("idle_lives", bus.lives, 0);

        // Game 2: tick coincident with hit, then simultaneous enemy/player hit on last life.
        start_game(1);
        bus.enemy_hit = 1'b1;
        step(41);
        bus.enemy_hit = 1'b0;
        check("score_41", bus.score, 16'h0041);
        player_hit_pulse();
        respawn_wait(60);
        bus.key_left   = 1'b1;
        bus.frame_tick = 1'b1;
        bus.player_hit = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        bus.player_hit = 1'b0;
        bus.key_left   = 1'b0;
        check("tick_hit_move", bus.move_left, 1);
        check("tick_hit_state", bus.state, 2);
        check("tick_hit_lives", bus.lives, 1);
        respawn_wait(60);
        bus.enemy_hit  = 1'b1;
        bus.player_hit = 1'b1;
        step();
        bus.enemy_hit  = 1'b0;
        bus.player_hit = 1'b0;
        check("both_score", bus.score, 16'h0042);
        check("both_lives", bus.lives, 0);
        check("both_state", bus.state, 3);
        check("both_over", bus.game_over, 1);
        over_wait(180);

        // Game 3: reset in the middle of a respawn.
        start_game(1);
        player_hit_pulse();
        check("g3_respawn", bus.state, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_state", bus.state, 0);
        check("mid_rst_lives", bus.lives, 0);
        check("mid_rst_score", bus.score, 0);
        check("mid_rst_run", bus.world_run, 0);
        check("mid_rst_over", bus.game_over, 0);
        check("mid_rst_moves", {bus.move_left, bus.move_right, bus.fire_req}, 0);
        step(2);
        start_game(1);
        bus.key_fire = 1'b1;
        tick();
        check("post_rst_fire", bus.fire_req, 1);
        bus.key_fire = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
